// File: rtl/automata_report_pkg.sv
// -----------------------------------------------------------------------------
// automata_report_pkg
// Shared types and constants for the cluster-0 automata report collector.
//   - NUM_REPORTS / OFFSET_W : default report-vector and symbol-offset widths
//   - report_rec_t           : one captured record {offset, reports}
//   - collector_state_e      : stream-tracking FSM states
//   - report_slot_e          : per-automaton report slot order
//   - report_bit_index()     : (automaton, slot) -> report_vec bit position
// -----------------------------------------------------------------------------
package automata_report_pkg;

  localparam int unsigned NUM_AUTOMATA        = 7;
  localparam int unsigned SLOTS_PER_AUTOMATON = 4;
  localparam int          NUM_REPORTS         = 28;
  localparam int          OFFSET_W            = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_DONE
  } collector_state_e;

  // Slot order inside each automaton's group of four report wires.
  typedef enum logic [1:0] {
    SLOT_OUT_4,
    SLOT_OUT_6,
    SLOT_OUT_9,
    SLOT_OUT_11
  } report_slot_e;

  typedef struct packed {
    logic [OFFSET_W-1:0]    offset;
    logic [NUM_REPORTS-1:0] reports;
  } report_rec_t;

  function automatic int unsigned report_bit_index(input int unsigned  automaton,
                                                   input report_slot_e slot);
    return automaton * SLOTS_PER_AUTOMATON + {30'd0, slot};
  endfunction

endpackage

// File: rtl/automata_report_fifo.sv
// -----------------------------------------------------------------------------
// automata_report_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rdata_o whenever empty_o is low; pop_i consumes it at the next edge.
// A push into a full FIFO is taken only when a pop happens on the same edge.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   push_i, wdata_i     : write request and data
//   full_o              : no free entry
//   pop_i, rdata_o      : consume head entry, head entry data
//   empty_o             : no valid entry
//   count_o             : current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module automata_report_fifo #(
  parameter int WIDTH = 60,
  parameter int DEPTH = 16   // power of two, >= 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so that equal low bits can mean either
  // empty (MSBs equal) or full (MSBs differ).
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count_o = wr_ptr_q - rd_ptr_q;
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/automata_report_collector.sv
// -----------------------------------------------------------------------------
// automata_report_collector
// Records every symbol cycle on which the cluster-0 automata stage raises any
// report, buffers {symbol offset, report vector} records in a FWFT FIFO and
// drains them over a valid/ready stream. Tracks stream start/end and pulses
// done once the stream has ended and every record has drained.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   run                 : symbol valid, aligned with report_vec
//   stream_start        : pulse, new stream (clears offset/drop/overflow)
//   stream_end          : pulse, last symbol presented this cycle
//   report_vec          : report bits, index = automaton*4 + slot
//   out_valid/out_ready : record stream handshake
//   out_offset          : symbol offset of the head record
//   out_reports         : report bits of the head record
//   overflow            : sticky, a record was dropped this stream
//   drop_count          : number of dropped records, saturating
//   busy                : FSM not idle
//   done                : one-cycle pulse at end of stream with FIFO drained
// -----------------------------------------------------------------------------
module automata_report_collector
  import automata_report_pkg::*;
#(
  parameter int NUM_REPORTS = automata_report_pkg::NUM_REPORTS,
  parameter int OFFSET_W    = automata_report_pkg::OFFSET_W,
  parameter int DEPTH       = 16,   // power of two, >= 2
  parameter int DROP_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   stream_start,
  input  logic                   stream_end,
  input  logic [NUM_REPORTS-1:0] report_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OFFSET_W-1:0]    out_offset,
  output logic [NUM_REPORTS-1:0] out_reports,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  output logic                   busy,
  output logic                   done
);

  localparam int REC_W = OFFSET_W + NUM_REPORTS;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  collector_state_e      state_q;
  logic                  busy_q, done_q;

  logic [OFFSET_W-1:0]   offset_q, offset_d;
  logic                  cap_valid_q, cap_valid_d;
  logic [REC_W-1:0]      cap_rec_q, cap_rec_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_W-1:0]     drop_q, drop_d;

  logic                  symbols_live;
  logic [OFFSET_W-1:0]   rec_offset;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, drop_rec;
  logic [REC_W-1:0]      fifo_rdata;
  // Occupancy is kept for debug visibility; nothing in this block needs it.
  logic [CNT_W-1:0]      unused_fifo_count;

  // ---------------------------------------------------------------------------
  // Capture, offset and drop bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    offset_d    = offset_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;

    // A stream_start cycle already belongs to the new stream, at offset 0.
    symbols_live = stream_start | (state_q == ST_ACTIVE);
    rec_offset   = stream_start ? '0 : offset_q;

    cap_valid_d = symbols_live & run & (|report_vec);
    cap_rec_d   = {rec_offset, report_vec};

    if (stream_start)              offset_d = {{(OFFSET_W-1){1'b0}}, run};
    else if (symbols_live && run)  offset_d = offset_q + 1'b1;

    // No bypass: an empty FIFO never pops, so a push into it is never returned
    // on the same edge.
    fifo_pop  = ~fifo_empty & out_ready;
    fifo_push = cap_valid_q & (~fifo_full | fifo_pop);
    drop_rec  = cap_valid_q & fifo_full & ~fifo_pop;

    // A new stream wins over a drop on the same edge: its counters start clean.
    if (stream_start) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end else if (drop_rec) begin
      overflow_d = 1'b1;
      if (!(&drop_q)) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset_q    <= '0;
      cap_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      offset_q    <= offset_d;
      cap_valid_q <= cap_valid_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  // Record payload is qualified by cap_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    cap_rec_q <= cap_rec_d;
  end

  // ---------------------------------------------------------------------------
  // Stream-tracking FSM with registered busy/done
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (stream_start) begin
      state_q <= ST_ACTIVE;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        ST_ACTIVE: begin
          if (stream_end) state_q <= ST_DRAIN;
          busy_q <= 1'b1;
          done_q <= 1'b0;
        end
        ST_DRAIN: begin
          // Wait for the capture register as well: a report on the
          // stream_end cycle is still on its way into the FIFO.
          if (!cap_valid_q && fifo_empty) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            done_q  <= 1'b0;
          end
          busy_q <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Record FIFO
  // ---------------------------------------------------------------------------
  automata_report_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .wdata_i (cap_rec_q),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

  // Payload is forced to zero while empty so stale RAM never reaches the port.
  always_comb begin
    out_valid   = ~fifo_empty;
    out_offset  = fifo_empty ? '0 : fifo_rdata[REC_W-1:NUM_REPORTS];
    out_reports = fifo_empty ? '0 : fifo_rdata[NUM_REPORTS-1:0];
    overflow    = overflow_q;
    drop_count  = drop_q;
    busy        = busy_q;
    done        = done_q;
  end

endmodule

// File: tb/tb_automata_report_collector.sv
// -----------------------------------------------------------------------------
// tb_automata_report_collector
// Directed scenarios plus a randomized stretch, checked every cycle against a
// queue-based reference model, with literal expectations on key records.
// -----------------------------------------------------------------------------
module tb_automata_report_collector;
  import automata_report_pkg::*;

  localparam int DEPTH    = 16;
  localparam int DROP_MAX = 65535;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   run = 1'b0;
  logic                   stream_start = 1'b0;
  logic                   stream_end = 1'b0;
  logic [NUM_REPORTS-1:0] report_vec = '0;
  logic                   out_ready = 1'b0;
  logic                   out_valid;
  logic [OFFSET_W-1:0]    out_offset;
  logic [NUM_REPORTS-1:0] out_reports;
  logic                   overflow;
  logic [15:0]            drop_count;
  logic                   busy;
  logic                   done;

  int total = 0;
  int bad   = 0;

  automata_report_collector #(
    .NUM_REPORTS (NUM_REPORTS),
    .OFFSET_W    (OFFSET_W),
    .DEPTH       (DEPTH),
    .DROP_W      (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .stream_start (stream_start),
    .stream_end   (stream_end),
    .report_vec   (report_vec),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_offset   (out_offset),
    .out_reports  (out_reports),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: records wait one edge after sampling, then join a
  // DEPTH-bounded queue; the stream lifecycle is tracked as a phase.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_LIVE, M_FLUSH, M_FIN} mphase_e;

  report_rec_t   mq[$];
  bit            m_pend = 1'b0;
  report_rec_t   m_pend_rec;
  logic [31:0]   m_off = '0;
  mphase_e       m_ph = M_IDLE;
  bit            m_ovf = 1'b0;
  int            m_drops = 0;
  bit            m_pop, m_live, m_settled;
  bit            force_req = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_pend  = 1'b0;
      m_off   = '0;
      m_ph    = M_IDLE;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      m_pop     = (mq.size() != 0) && out_ready;
      m_settled = !m_pend && (mq.size() == 0);
      if (m_pop) void'(mq.pop_front());
      if (m_pend) begin
        if (mq.size() < DEPTH) mq.push_back(m_pend_rec);
        else if (!stream_start) begin
          m_ovf = 1'b1;
          if (m_drops < DROP_MAX) m_drops++;
        end
      end
      m_live = stream_start || (m_ph == M_LIVE);
      m_pend = m_live && run && (report_vec != '0);
      m_pend_rec.offset  = stream_start ? 32'd0 : m_off;
      m_pend_rec.reports = report_vec;
      if (stream_start)        m_off = run ? 32'd1 : 32'd0;
      else if (m_live && run)  m_off = m_off + 32'd1;
      if (force_req)           m_off = 32'hFFFF_FFFF;
      if (stream_start) begin
        m_ph    = M_LIVE;
        m_ovf   = 1'b0;
        m_drops = 0;
      end else begin
        case (m_ph)
          M_LIVE:  if (stream_end) m_ph = M_FLUSH;
          M_FLUSH: if (m_settled) m_ph = M_FIN;
          M_FIN:   m_ph = M_IDLE;
          default: m_ph = M_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare and log of records actually handed over by the DUT
  // ---------------------------------------------------------------------------
  report_rec_t dut_log[$];
  report_rec_t seen;

  always @(negedge clk) begin
    check("out_valid", out_valid, mq.size() != 0);
    if (out_valid && mq.size() != 0) begin
      check("out_offset", out_offset, mq[0].offset);
      check("out_reports", out_reports, mq[0].reports);
    end
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drops);
    check("busy", busy, m_ph != M_IDLE);
    check("done", done, m_ph == M_FIN);
    if (!reset && out_valid && out_ready) begin
      seen.offset  = out_offset;
      seen.reports = out_reports;
      dut_log.push_back(seen);
    end
  end

  task automatic step(input bit st, input bit en, input bit rn,
                      input logic [NUM_REPORTS-1:0] rv, input bit rdy);
    stream_start = st;
    stream_end   = en;
    run          = rn;
    report_vec   = rv;
    out_ready    = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic check_rec(input string name, input int idx,
                           input logic [31:0] off, input logic [NUM_REPORTS-1:0] rv);
    if (idx < dut_log.size()) begin
      check({name, "_off"}, dut_log[idx].offset, off);
      check({name, "_rep"}, dut_log[idx].reports, rv);
    end else begin
      check({name, "_present"}, dut_log.size(), idx + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [NUM_REPORTS-1:0] rv_a, rv_b, rv_r;
  int log_size;
  bit st_r, en_r, rn_r, rdy_r;

  initial begin
    // ---------------- reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_drop", drop_count, 16'd0);
    reset = 1'b0;

    // ---------------- two sparse reports, ready high
    check("bit_idx_a6_out11", report_bit_index(6, SLOT_OUT_11), 27);
    rv_a = 28'd1 << report_bit_index(0, SLOT_OUT_4);
    rv_b = 28'd1 << report_bit_index(6, SLOT_OUT_11);
    dut_log.delete();
    step(1, 0, 0, '0, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, (i == 3) ? rv_a : ((i == 7) ? rv_b : '0), 1);
      if (i == 3 || i == 7) check("lat_early", out_valid, 1'b0);
      if (i == 4 || i == 8) begin
        check("lat_valid", out_valid, 1'b1);
        check("lat_offset", out_offset, i - 1);
      end
    end
    step(0, 1, 0, '0, 1);
    repeat (4) step(0, 0, 0, '0, 1);
    check("t1_count", dut_log.size(), 2);
    check_rec("t1_rec0", 0, 32'd3, 28'h0000001);
    check_rec("t1_rec1", 1, 32'd7, 28'h8000000);

    // ---------------- overflow with ready low, then push+pop while full
    dut_log.delete();
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 28'h10 | 28'(i), 0);
    step(0, 0, 1, 28'h100, 0);
    check("t2_ovf", overflow, 1'b1);
    check("t2_drop", drop_count, 16'd4);
    check("t2_count", dut.u_fifo.count_o, 16);
    step(0, 0, 0, '0, 1);
    check("t3_drop", drop_count, 16'd4);
    check("t3_count", dut.u_fifo.count_o, 16);
    repeat (20) step(0, 0, 0, '0, 1);
    check("t2_drained", dut_log.size(), 17);
    for (int k = 0; k < 16; k++) check_rec("t2_order", k, k, 28'h10 | 28'(k));
    check_rec("t3_late", 16, 32'd20, 28'h100);
    step(0, 1, 0, '0, 1);
    repeat (3) step(0, 0, 0, '0, 1);

    // ---------------- report on stream_end, held back, done timing
    dut_log.delete();
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, '0, 0);
    step(0, 1, 1, 28'h0A5A5A5, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, '0, 0);
      check("t4_busy_hold", busy, 1'b1);
      check("t4_done_hold", done, 1'b0);
    end
    step(0, 0, 0, '0, 1);
    check("t4_done_at_pop", done, 1'b0);
    check_rec("t4_rec", 0, 32'd5, 28'h0A5A5A5);
    step(0, 0, 0, '0, 1);
    check("t4_done_pulse", done, 1'b1);
    step(0, 0, 0, '0, 1);
    check("t4_done_clear", done, 1'b0);
    check("t4_idle", busy, 1'b0);

    // ---------------- offset wrap
    dut_log.delete();
    step(1, 0, 0, '0, 1);
    step(0, 0, 1, '0, 1);
    force dut.offset_q = 32'hFFFF_FFFF;
    force_req = 1'b1;
    step(0, 0, 0, '0, 1);
    release dut.offset_q;
    force_req = 1'b0;
    step(0, 0, 1, 28'h0000F00, 1);
    step(0, 0, 1, 28'h00F0000, 1);
    step(0, 1, 0, '0, 1);
    repeat (4) step(0, 0, 0, '0, 1);
    check_rec("t5_max", 0, 32'hFFFF_FFFF, 28'h0000F00);
    check_rec("t5_wrap", 1, 32'h0000_0000, 28'h00F0000);

    // ---------------- randomized traffic
    step(1, 0, 0, '0, 1);
    for (int c = 0; c < 500; c++) begin
      st_r  = ($urandom_range(0, 119) == 0);
      en_r  = ($urandom_range(0, 69) == 0);
      rn_r  = !st_r && ($urandom_range(0, 3) != 0);
      rv_r  = ($urandom_range(0, 2) == 0) ? (28'($urandom) & 28'($urandom)) : '0;
      rdy_r = ((c % 100) < 40) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      step(st_r, en_r, rn_r, rv_r, rdy_r);
    end
    step(0, 1, 0, '0, 1);
    repeat (40) step(0, 0, 0, '0, 1);

    // ---------------- reset with records queued
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 28'h1 << i, 0);
    repeat (2) step(0, 0, 0, '0, 0);
    check("t6_queued", dut.u_fifo.count_o, 3);
    reset = 1'b1;
    #1;
    check("t6_valid", out_valid, 1'b0);
    check("t6_ovf", overflow, 1'b0);
    check("t6_busy", busy, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    log_size = dut_log.size();
    repeat (6) step(0, 0, 0, '0, 1);
    check("t6_no_records", dut_log.size(), log_size);
    check("t6_valid_after", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
